// File: rtl/ap_ctrl_pkg.sv
// Shared types and default sizing for the HLS block-level control launcher.
// Imported by the launcher top and its timestamp FIFO.
package ap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_e;

    localparam int CNT_W_DEF = 32;
    localparam int NUM_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/ap_ctrl_launcher_if.sv
// Kernel block-level control handshake (ap_start/ap_ready/ap_done/ap_continue).
// master = launcher side, slave = generated kernel side.
interface ap_ctrl_launcher_if;

    logic k_ap_start;
    logic k_ap_ready;
    logic k_ap_done;
    logic k_ap_continue;

    modport master (
        output k_ap_start,
        output k_ap_continue,
        input  k_ap_ready,
        input  k_ap_done
    );

    modport slave (
        input  k_ap_start,
        input  k_ap_continue,
        output k_ap_ready,
        output k_ap_done
    );

endinterface

// File: rtl/ap_ctrl_ts_fifo.sv
// Small synchronous FIFO carrying {start timestamp, interval} per transaction.
// Same-cycle push and pop are allowed; ap_rst flushes it.
import ap_ctrl_pkg::*;

module ap_ctrl_ts_fifo #(
    parameter int W     = 2 * CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        unique case (1'b1)
            do_push && !do_pop: cnt_d = cnt_q + (AW+1)'(1);
            do_pop && !do_push: cnt_d = cnt_q - (AW+1)'(1);
            default:            cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ap_ctrl_launcher.sv
// Issues N kernel invocations (serial or chained) over ap_ctrl_hs and
// reports per-transaction latency and start-to-start interval.
import ap_ctrl_pkg::*;

module ap_ctrl_launcher #(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [NUM_W-1:0] cmd_count,
    input  logic             cmd_chain,
    ap_ctrl_launcher_if.master kif,
    output logic             busy,
    output logic             stat_valid,
    output logic [NUM_W-1:0] stat_index,
    output logic [CNT_W-1:0] stat_latency,
    output logic [CNT_W-1:0] stat_interval,
    output logic             done_pulse
);

    localparam int OW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             hold_q, hold_d;
    logic [NUM_W-1:0] count_q, count_d;
    logic             chain_q, chain_d;
    logic [NUM_W-1:0] issued_q, issued_d;
    logic [NUM_W-1:0] cmpl_q, cmpl_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic             sv_q, sv_d;
    logic [NUM_W-1:0] sidx_q, sidx_d;
    logic [CNT_W-1:0] slat_q, slat_d;
    logic [CNT_W-1:0] sint_q, sint_d;

    logic               active;
    logic               start;
    logic               accept;
    logic               cmpl;
    logic               f_full;
    logic               f_empty;
    logic [CNT_W-1:0]   rise_ts;
    logic [CNT_W-1:0]   int_push;
    logic [CNT_W-1:0]   ts_pop;
    logic [CNT_W-1:0]   int_pop;
    logic [2*CNT_W-1:0] pop_data;

    assign active = (state_q == RUN) || (state_q == DRAIN);

    assign start = (state_q == RUN)
                && (issued_q < count_q)
                && (outst_q < OW'(DEPTH))
                && !f_full
                && (chain_q || (outst_q == '0));

    assign kif.k_ap_start    = start;
    assign kif.k_ap_continue = kif.k_ap_done && active;

    assign accept = start && kif.k_ap_ready;
    assign cmpl   = kif.k_ap_done && active && !f_empty;

    // Timestamp is held from the first cycle start was raised, not the accept.
    assign rise_ts  = hold_q ? rise_q : tick_q;
    assign int_push = (issued_q == '0) ? '0 : tick_q - prev_q;
    assign {ts_pop, int_pop} = pop_data;

    ap_ctrl_ts_fifo #(
        .W     (2 * CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .push  (accept),
        .wdata ({rise_ts, int_push}),
        .pop   (cmpl),
        .rdata (pop_data),
        .full  (f_full),
        .empty (f_empty)
    );

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q + CNT_W'(1);
        rise_d   = rise_q;
        prev_d   = prev_q;
        hold_d   = 1'b0;
        count_d  = count_q;
        chain_d  = chain_q;
        issued_d = issued_q;
        cmpl_d   = cmpl_q;
        outst_d  = outst_q;
        sv_d     = 1'b0;
        sidx_d   = sidx_q;
        slat_d   = slat_q;
        sint_d   = sint_q;

        if (start && !kif.k_ap_ready) begin
            hold_d = 1'b1;
            rise_d = rise_ts;
        end
        if (accept) begin
            issued_d = issued_q + NUM_W'(1);
            prev_d   = tick_q;
        end
        if (cmpl) begin
            sv_d   = 1'b1;
            sidx_d = cmpl_q;
            slat_d = tick_q - ts_pop;
            sint_d = int_pop;
            cmpl_d = cmpl_q + NUM_W'(1);
        end

        unique case (1'b1)
            accept && !cmpl: outst_d = outst_q + OW'(1);
            cmpl && !accept: outst_d = outst_q - OW'(1);
            default:         outst_d = outst_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    count_d  = cmd_count;
                    chain_d  = cmd_chain;
                    issued_d = '0;
                    cmpl_d   = '0;
                    state_d  = (cmd_count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issued_q == count_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Last stat is on the outputs in the cycle this fires.
                if (outst_q == '0 && cmpl_q == count_q) state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            rise_q   <= '0;
            prev_q   <= '0;
            hold_q   <= 1'b0;
            count_q  <= '0;
            chain_q  <= 1'b0;
            issued_q <= '0;
            cmpl_q   <= '0;
            outst_q  <= '0;
            sv_q     <= 1'b0;
            sidx_q   <= '0;
            slat_q   <= '0;
            sint_q   <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            rise_q   <= rise_d;
            prev_q   <= prev_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            chain_q  <= chain_d;
            issued_q <= issued_d;
            cmpl_q   <= cmpl_d;
            outst_q  <= outst_d;
            sv_q     <= sv_d;
            sidx_q   <= sidx_d;
            slat_q   <= slat_d;
            sint_q   <= sint_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done_pulse    = (state_q == FIN);
    assign stat_valid    = sv_q;
    assign stat_index    = sidx_q;
    assign stat_latency  = slat_q;
    assign stat_interval = sint_q;

endmodule

// File: tb/tb_ap_ctrl_launcher.sv
// Directed bench for ap_ctrl_launcher with a behavioural HLS kernel model.
// Narrow tick counter so the wrap case is reachable in a few hundred cycles.
module tb_ap_ctrl_launcher;

    localparam int CNT_W = 8;
    localparam int NUM_W = 16;
    localparam int DEPTH = 4;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [NUM_W-1:0] cmd_count = '0;
    logic             cmd_chain = 1'b0;
    logic             busy;
    logic             stat_valid;
    logic [NUM_W-1:0] stat_index;
    logic [CNT_W-1:0] stat_latency;
    logic [CNT_W-1:0] stat_interval;
    logic             done_pulse;

    ap_ctrl_launcher_if kif();

    ap_ctrl_launcher #(
        .CNT_W (CNT_W),
        .NUM_W (NUM_W),
        .DEPTH (DEPTH)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_count     (cmd_count),
        .cmd_chain     (cmd_chain),
        .kif           (kif),
        .busy          (busy),
        .stat_valid    (stat_valid),
        .stat_index    (stat_index),
        .stat_latency  (stat_latency),
        .stat_interval (stat_interval),
        .done_pulse    (done_pulse)
    );

    always #5 ap_clk = ~ap_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Kernel model: ready always, done lat cycles after accept, in order.
    int cyc = 0;
    int lat = 10;
    int due_q[$];

    always @(posedge ap_clk) begin
        if (ap_rst) begin
            cyc = 0;
            due_q.delete();
        end else begin
            if (kif.k_ap_done && kif.k_ap_continue && due_q.size() != 0)
                void'(due_q.pop_front());
            if (kif.k_ap_start && kif.k_ap_ready)
                due_q.push_back(cyc + lat);
            cyc = cyc + 1;
        end
    end

    always @(negedge ap_clk)
        kif.k_ap_done = (due_q.size() != 0) && (due_q[0] <= cyc);

    // Monitor
    int st_idx[$];
    int st_lat[$];
    int st_int[$];
    int dp_cnt, dp_at, last_sv, start_cnt, gate_viol, max_out;
    bit serial_chk = 1'b0;

    always @(negedge ap_clk) begin
        if (stat_valid) begin
            st_idx.push_back(int'(stat_index));
            st_lat.push_back(int'(stat_latency));
            st_int.push_back(int'(stat_interval));
            last_sv = cyc;
        end
        if (done_pulse) begin
            dp_cnt++;
            dp_at = cyc;
        end
        if (due_q.size() > max_out) max_out = due_q.size();
        if (kif.k_ap_start) begin
            start_cnt++;
            if (due_q.size() >= DEPTH) gate_viol++;
            if (serial_chk && due_q.size() != 0) gate_viol++;
        end
    end

    task automatic clear_mon();
        st_idx.delete();
        st_lat.delete();
        st_int.delete();
        dp_cnt = 0;
        dp_at = 0;
        last_sv = 0;
        start_cnt = 0;
        gate_viol = 0;
        max_out = 0;
    endtask

    task automatic send_cmd(input int cnt, input bit chain);
        @(negedge ap_clk);
        cmd_valid = 1'b1;
        cmd_count = cnt[NUM_W-1:0];
        cmd_chain = chain;
        @(negedge ap_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge ap_clk);
            if (done_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        expect_eq({tag, "_done_seen"}, seen, 1);
        @(negedge ap_clk);
        expect_eq({tag, "_cmd_ready_back"}, cmd_ready, 1);
        expect_eq({tag, "_done_pulses"}, dp_cnt, 1);
    endtask

    task automatic chk_reset(input string p);
        expect_eq({p, "_cmd_ready"}, cmd_ready, 1);
        expect_eq({p, "_busy"}, busy, 0);
        expect_eq({p, "_start"}, kif.k_ap_start, 0);
        expect_eq({p, "_continue"}, kif.k_ap_continue, 0);
        expect_eq({p, "_stat_valid"}, stat_valid, 0);
        expect_eq({p, "_stat_index"}, stat_index, 0);
        expect_eq({p, "_stat_latency"}, stat_latency, 0);
        expect_eq({p, "_stat_interval"}, stat_interval, 0);
        expect_eq({p, "_done_pulse"}, done_pulse, 0);
    endtask

    int ser_int[3] = '{0, 11, 11};
    int chn_int[8] = '{0, 1, 1, 1, 18, 1, 1, 1};

    initial begin
        bit hit;
        kif.k_ap_ready = 1'b1;
        clear_mon();

        repeat (2) @(negedge ap_clk);
        chk_reset("rst");
        ap_rst = 1'b0;

        // Serial, count 3, latency 10
        clear_mon();
        serial_chk = 1'b1;
        lat = 10;
        send_cmd(3, 1'b0);
        expect_eq("ser_start_t1", kif.k_ap_start, 1);
        expect_eq("ser_busy_t1", busy, 1);
        wait_done("ser", 200);
        expect_eq("ser_nstat", st_idx.size(), 3);
        for (int i = 0; i < 3 && i < st_idx.size(); i++) begin
            expect_eq($sformatf("ser_idx%0d", i), st_idx[i], i);
            expect_eq($sformatf("ser_lat%0d", i), st_lat[i], 10);
            expect_eq($sformatf("ser_int%0d", i), st_int[i], ser_int[i]);
        end
        expect_eq("ser_dp_after_stat", dp_at - last_sv, 1);
        expect_eq("ser_gate", gate_viol, 0);
        serial_chk = 1'b0;

        // Chained, count 8, latency 20
        clear_mon();
        lat = 20;
        send_cmd(8, 1'b1);
        expect_eq("chn_start_t1", kif.k_ap_start, 1);
        wait_done("chn", 400);
        expect_eq("chn_nstat", st_idx.size(), 8);
        for (int i = 0; i < 8 && i < st_idx.size(); i++) begin
            expect_eq($sformatf("chn_idx%0d", i), st_idx[i], i);
            expect_eq($sformatf("chn_lat%0d", i), st_lat[i], 20);
            expect_eq($sformatf("chn_int%0d", i), st_int[i], chn_int[i]);
        end
        expect_eq("chn_max_out", max_out, DEPTH);
        expect_eq("chn_gate", gate_viol, 0);
        expect_eq("chn_dp_after_stat", dp_at - last_sv, 1);

        // Zero-count command
        clear_mon();
        send_cmd(0, 1'b0);
        expect_eq("z_done_t1", done_pulse, 1);
        expect_eq("z_busy_t1", busy, 1);
        expect_eq("z_ready_t1", cmd_ready, 0);
        @(negedge ap_clk);
        expect_eq("z_ready_t2", cmd_ready, 1);
        expect_eq("z_done_t2", done_pulse, 0);
        expect_eq("z_busy_t2", busy, 0);
        expect_eq("z_no_start", start_cnt, 0);
        expect_eq("z_no_stat", st_idx.size(), 0);

        // Tick wrap: start-rise at 2^8-3, done at 2^8+4
        clear_mon();
        lat = 7;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge ap_clk);
            if ((cyc % 256) == 251) begin
                hit = 1'b1;
                break;
            end
        end
        expect_eq("wrap_align", hit, 1);
        send_cmd(1, 1'b0);
        wait_done("wrap", 100);
        expect_eq("wrap_nstat", st_idx.size(), 1);
        if (st_idx.size() != 0) begin
            expect_eq("wrap_lat", st_lat[0], 7);
            expect_eq("wrap_idx", st_idx[0], 0);
            expect_eq("wrap_int", st_int[0], 0);
        end

        // Reset with two transactions outstanding
        clear_mon();
        lat = 20;
        send_cmd(2, 1'b1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        expect_eq("mid_busy", busy, 1);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk_reset("mid_rst");
        ap_rst = 1'b0;
        clear_mon();
        lat = 5;
        send_cmd(1, 1'b0);
        wait_done("post", 100);
        expect_eq("post_nstat", st_idx.size(), 1);
        if (st_idx.size() != 0) begin
            expect_eq("post_idx", st_idx[0], 0);
            expect_eq("post_lat", st_lat[0], 5);
            expect_eq("post_int", st_int[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
